// File: rtl/ac_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ac_seq_pkg
//  Description : Shared types and encodings for the accumulate-then-shift
//                micro-sequencer: FSM state enum, ALU opcodes, AC control
//                codes and the post-operand state selection helper.
//                Optional macro AC_SEQ_ROUND_EN enables round-half-up
//                averaging (extra ROUND step before a right shift).
//  Revision    : 1.0 - initial release
// ============================================================================
package ac_seq_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      CLEAR = 3'd1,
      LOAD  = 3'd2,
      ACCUM = 3'd3,
      ROUND = 3'd4,
      SHIFT = 3'd5,
      DONE  = 3'd6
   } state_t;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SHR = 3'b100;
   localparam logic [2:0] ALU_SHL = 3'b101;

   localparam logic [1:0] AC_HOLD   = 2'b00;
   localparam logic [1:0] AC_LD_BUS = 2'b10;
   localparam logic [1:0] AC_LD_ALU = 2'b11;

`ifdef AC_SEQ_ROUND_EN
   localparam bit ROUND_EN = 1'b1;
`else
   localparam bit ROUND_EN = 1'b0;
`endif

   // State entered once the last operand has been absorbed into AC.
   function automatic state_t post_ops_state(input logic dir, input logic [3:0] shift);
      state_t nxt;
      if (shift == 4'd0)
         nxt = DONE;
      else if (ROUND_EN && !dir && (shift <= 4'd7))
         nxt = ROUND;
      else
         nxt = SHIFT;
      return nxt;
   endfunction

endpackage : ac_seq_pkg
`default_nettype wire

// File: rtl/ac_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : ac_seq_ctrl
//  Description : Micro-sequencer driving an external AC/ALU datapath through
//                one "accumulate N operands, then shift" command. Commands,
//                operands and results travel over valid/ready streams; one
//                datapath micro-op is issued per cycle.
//                Optional macro AC_SEQ_ROUND_EN inserts a ROUND step
//                (adds 1<<(shift-1)) before right shifts of 1..7.
//  Revision    : 1.0 - initial release
// ============================================================================
module ac_seq_ctrl
   import ac_seq_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int CNT_W  = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_dir,
   input  logic [CNT_W-1:0]  cmd_count,
   input  logic [3:0]        cmd_shift,
   input  logic              opnd_valid,
   output logic              opnd_ready,
   input  logic [DATA_W-1:0] opnd_data,
   output logic [1:0]        ac_control,
   output logic [2:0]        alu_control,
   output logic [DATA_W-1:0] bus_to_ac,
   output logic [6:0]        inst_to_alu,
   input  logic [DATA_W-1:0] ac_to_bus,
   input  logic              z_flag,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [DATA_W-1:0] res_data,
   output logic              res_zero,
   output logic              busy
);

   state_t             r_state;
   state_t             w_next_state;
   state_t             w_after_ops;
   logic               r_dir;
   logic [3:0]         r_shift;
   logic [CNT_W-1:0]   r_remaining;
   logic               w_opnd_hs;
   logic               w_last;

   assign w_opnd_hs   = opnd_valid & opnd_ready;
   // The operand being accepted now is the final one when at most one remains.
   assign w_last      = (r_remaining <= CNT_W'(1));
   assign w_after_ops = post_ops_state(r_dir, r_shift);

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_state <= IDLE;
      else
         r_state <= w_next_state;
   end

   // Command context capture and remaining-operand counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_dir       <= 1'b0;
         r_shift     <= 4'd0;
         r_remaining <= '0;
      end else if ((r_state == IDLE) && cmd_valid) begin
         r_dir       <= cmd_dir;
         r_shift     <= cmd_shift;
         r_remaining <= cmd_count;
      end else if (w_opnd_hs) begin
         r_remaining <= r_remaining - CNT_W'(1);
      end
   end

   // Next-state and datapath micro-op decode.
   always_comb begin
      w_next_state = r_state;
      cmd_ready    = 1'b0;
      opnd_ready   = 1'b0;
      res_valid    = 1'b0;
      res_data     = '0;
      res_zero     = 1'b0;
      busy         = 1'b1;
      ac_control   = AC_HOLD;
      alu_control  = ALU_ADD;
      bus_to_ac    = '0;
      inst_to_alu  = 7'd0;

      case (r_state)
         IDLE: begin
            cmd_ready = 1'b1;
            busy      = 1'b0;
            if (cmd_valid)
               w_next_state = (cmd_count != '0) ? LOAD : CLEAR;
         end

         CLEAR: begin
            ac_control   = AC_LD_BUS;
            w_next_state = DONE;
         end

         LOAD: begin
            opnd_ready = 1'b1;
            bus_to_ac  = opnd_data;
            if (opnd_valid) begin
               ac_control   = AC_LD_BUS;
               w_next_state = w_last ? w_after_ops : ACCUM;
            end
         end

         ACCUM: begin
            opnd_ready  = 1'b1;
            bus_to_ac   = opnd_data;
            alu_control = ALU_ADD;
            if (opnd_valid) begin
               ac_control   = AC_LD_ALU;
               w_next_state = w_last ? w_after_ops : ACCUM;
            end
         end

`ifdef AC_SEQ_ROUND_EN
         ROUND: begin
            ac_control   = AC_LD_ALU;
            alu_control  = ALU_ADD;
            inst_to_alu  = 7'd1 << (r_shift - 4'd1);
            w_next_state = SHIFT;
         end
`endif

         SHIFT: begin
            ac_control   = AC_LD_ALU;
            alu_control  = r_dir ? ALU_SHL : ALU_SHR;
            inst_to_alu  = {3'b000, r_shift};
            w_next_state = DONE;
         end

         DONE: begin
            res_valid = 1'b1;
            res_data  = ac_to_bus;
            res_zero  = z_flag;
            if (res_ready)
               w_next_state = IDLE;
         end

         default: begin
            w_next_state = IDLE;
         end
      endcase
   end

endmodule : ac_seq_ctrl
`default_nettype wire

// File: tb/tb_ac_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ac_seq_ctrl
//  Description : Self-checking bench for ac_seq_ctrl with a behavioural
//                AC/ALU datapath and an arithmetic result reference.
//                Honours AC_SEQ_ROUND_EN for expected values.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ac_seq_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cmd_valid, cmd_ready, cmd_dir;
   logic [3:0]  cmd_count, cmd_shift;
   logic        opnd_valid, opnd_ready;
   logic [15:0] opnd_data;
   logic [1:0]  ac_control;
   logic [2:0]  alu_control;
   logic [15:0] bus_to_ac;
   logic [6:0]  inst_to_alu;
   logic [15:0] ac_to_bus;
   logic        z_flag;
   logic        res_valid, res_ready;
   logic [15:0] res_data;
   logic        res_zero;
   logic        busy;

   int n_pass  = 0;
   int n_total = 0;

   logic [15:0] ops [16];

   always #5 clk = ~clk;

   ac_seq_ctrl #(.DATA_W(16), .CNT_W(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_dir(cmd_dir),
      .cmd_count(cmd_count), .cmd_shift(cmd_shift),
      .opnd_valid(opnd_valid), .opnd_ready(opnd_ready), .opnd_data(opnd_data),
      .ac_control(ac_control), .alu_control(alu_control),
      .bus_to_ac(bus_to_ac), .inst_to_alu(inst_to_alu),
      .ac_to_bus(ac_to_bus), .z_flag(z_flag),
      .res_valid(res_valid), .res_ready(res_ready),
      .res_data(res_data), .res_zero(res_zero), .busy(busy)
   );

   // Behavioural datapath: AC register plus ADD/SHR/SHL ALU.
   logic [15:0] ac_reg = 16'h5A5A;
   logic [15:0] alu_y;
   assign alu_y = (alu_control == 3'b000) ? ac_reg + bus_to_ac + {9'd0, inst_to_alu} :
                  (alu_control == 3'b100) ? ac_reg >> inst_to_alu :
                  (alu_control == 3'b101) ? ac_reg << inst_to_alu : ac_reg;
   always @(posedge clk) if (ac_control[1]) ac_reg <= ac_control[0] ? alu_y : bus_to_ac;
   assign ac_to_bus = ac_reg;
   assign z_flag    = (ac_reg == 16'd0);

   // Expected result: wrapping sum, optional rounding, then shift.
   function automatic logic [15:0] ref_result(input logic d, input int cnt, input int sh);
      logic [31:0] acc = 0;
      if (cnt == 0) return 16'd0;
      for (int i = 0; i < cnt; i++) acc = (acc + ops[i]) % 65536;
`ifdef AC_SEQ_ROUND_EN
      if (!d && sh >= 1 && sh <= 7) acc = (acc + (32'd1 << (sh - 1))) % 65536;
`endif
      if (d) acc = (acc << sh) % 65536;
      else   acc = acc >> sh;
      return acc[15:0];
   endfunction

   // Expected edges from command handshake (inclusive) to res_valid, no bubbles.
   function automatic int ref_edges(input logic d, input int cnt, input int sh);
      int e;
      if (cnt == 0) return 2;
      e = cnt + 1 + ((sh != 0) ? 1 : 0);
`ifdef AC_SEQ_ROUND_EN
      if (!d && sh >= 1 && sh <= 7) e++;
`endif
      return e;
   endfunction

   // Issue one command, feed ops[] with bubbles, return at first res_valid.
   task automatic run_cmd(input logic d, input int cnt, input int sh,
                          input int bmin, input int bmax, input bit junk,
                          output logic [15:0] rd, output logic rz, output int edges,
                          output int nhs, output int bad_wr, output int ordy, output bit ok);
      int bub, idx, budget;
      ok = 0; edges = 0; nhs = 0; bad_wr = 0; ordy = 0; rd = '0; rz = 1'b0;
      budget = 0;
      @(negedge clk);
      cmd_valid = 1'b1; cmd_dir = d; cmd_count = 4'(cnt); cmd_shift = 4'(sh);
      while (1) begin
         #1;
         if (cmd_ready) break;
         budget++;
         if (budget > 50) begin cmd_valid = 1'b0; return; end
         @(negedge clk);
      end
      @(posedge clk);
      edges = 1;
      idx = 0;
      bub = $urandom_range(bmax, bmin);
      for (int cyc = 0; cyc < 400; cyc++) begin
         @(negedge clk);
         cmd_valid = 1'b0;
         if (idx < cnt) begin
            if (bub > 0) begin opnd_valid = 1'b0; bub--; end
            else begin opnd_valid = 1'b1; opnd_data = ops[idx]; end
         end else begin
            opnd_valid = junk ? 1'($urandom_range(1, 0)) : 1'b0;
            opnd_data  = 16'hDEAD;
         end
         #1;
         if (res_valid) begin
            rd = res_data; rz = res_zero; opnd_valid = 1'b0; ok = 1; return;
         end
         if (opnd_ready) ordy++;
         if (opnd_ready && !opnd_valid && ac_control[1]) bad_wr++;
         if (opnd_valid && opnd_ready) begin
            nhs++;
            if (idx < cnt) idx++;
            bub = $urandom_range(bmax, bmin);
         end
         @(posedge clk);
         edges++;
      end
      opnd_valid = 1'b0;
   endtask

   // Accept the pending result (call in the low clock phase).
   task automatic finish_res();
      res_ready = 1'b1;
      @(posedge clk);
      #1;
      res_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; cmd_valid = 1'b1; opnd_valid = 1'b1; opnd_data = 16'h1234;
      res_ready = 1'b1; cmd_dir = 1'b0; cmd_count = 4'd3; cmd_shift = 4'd1;
      repeat (3) @(posedge clk);
      @(negedge clk); #1;
      n_total++;
      if ({cmd_ready, opnd_ready, res_valid, busy} !== 4'b1000) begin
         $display("FAIL reset_hs got=%b exp=1000", {cmd_ready, opnd_ready, res_valid, busy});
      end else n_pass++;
      n_total++;
      if ({ac_control, alu_control, bus_to_ac, inst_to_alu} !== 28'd0) begin
         $display("FAIL reset_dp got ac=%b alu=%b bus=%h inst=%h exp all zero",
                  ac_control, alu_control, bus_to_ac, inst_to_alu);
      end else n_pass++;
      cmd_valid = 1'b0; opnd_valid = 1'b0; res_ready = 1'b0;
      @(negedge clk); rst_n = 1'b1;
   endtask

   task automatic test_average();
      logic [15:0] rd; logic rz; int e, nhs, bw, orq; bit ok;
      ops[0] = 16'd10; ops[1] = 16'd20; ops[2] = 16'd30; ops[3] = 16'd42;
      run_cmd(1'b0, 4, 2, 0, 0, 1'b0, rd, rz, e, nhs, bw, orq, ok);
      n_total++;
      if (!ok) $display("FAIL avg_timeout got=timeout exp=res_valid");
      else n_pass++;
`ifdef AC_SEQ_ROUND_EN
      n_total++;
      if (rd !== 16'd26 || rz !== 1'b0) $display("FAIL avg_data got=%0d/%b exp=26/0", rd, rz);
      else n_pass++;
      n_total++;
      if (e != 7) $display("FAIL avg_latency got=%0d exp=7", e);
      else n_pass++;
`else
      n_total++;
      if (rd !== 16'd25 || rz !== 1'b0) $display("FAIL avg_data got=%0d/%b exp=25/0", rd, rz);
      else n_pass++;
      n_total++;
      if (e != 6) $display("FAIL avg_latency got=%0d exp=6", e);
      else n_pass++;
`endif
      n_total++;
      if (nhs != 4) $display("FAIL avg_opnds got=%0d exp=4", nhs);
      else n_pass++;
      finish_res();
   endtask

   task automatic test_empty();
      logic [15:0] rd; logic rz; int e, nhs, bw, orq; bit ok;
      run_cmd(1'b0, 0, 3, 0, 0, 1'b1, rd, rz, e, nhs, bw, orq, ok);
      n_total++;
      if (!ok || rd !== 16'd0 || rz !== 1'b1)
         $display("FAIL empty_data got=ok%0d %h/%b exp=ok1 0000/1", ok, rd, rz);
      else n_pass++;
      n_total++;
      if (orq != 0 || nhs != 0) $display("FAIL empty_opnd_ready got=%0d pulses exp=0", orq);
      else n_pass++;
      n_total++;
      if (e != 2) $display("FAIL empty_latency got=%0d exp=2", e);
      else n_pass++;
      finish_res();
   endtask

   task automatic test_wrap_shl();
      logic [15:0] rd; logic rz; int e, nhs, bw, orq; bit ok;
      ops[0] = 16'hFFFF; ops[1] = 16'h0002;
      run_cmd(1'b1, 2, 3, 0, 0, 1'b1, rd, rz, e, nhs, bw, orq, ok);
      n_total++;
      if (!ok || rd !== 16'h0008 || rz !== 1'b0)
         $display("FAIL wrap_shl got=ok%0d %h/%b exp=ok1 0008/0", ok, rd, rz);
      else n_pass++;
      n_total++;
      if (e != 4 || nhs != 2) $display("FAIL wrap_latency got=%0d/%0d exp=4/2", e, nhs);
      else n_pass++;
      finish_res();
   endtask

   task automatic test_stalls();
      logic [15:0] rd, exp; logic rz; int e, nhs, bw, orq; bit ok;
      ops[0] = 16'd100; ops[1] = 16'd7; ops[2] = 16'd300;
      exp = ref_result(1'b0, 3, 1);
      run_cmd(1'b0, 3, 1, 3, 3, 1'b0, rd, rz, e, nhs, bw, orq, ok);
      n_total++;
      if (!ok || rd !== exp) $display("FAIL stall_data got=ok%0d %0d exp=ok1 %0d", ok, rd, exp);
      else n_pass++;
      n_total++;
      if (bw != 0) $display("FAIL stall_no_write got=%0d writes exp=0", bw);
      else n_pass++;
      for (int k = 0; k < 5; k++) begin
         cmd_valid = 1'b1; cmd_count = 4'd1;
         @(posedge clk); @(negedge clk); #1;
         n_total++;
         if (!res_valid || res_data !== rd || res_zero !== rz || cmd_ready !== 1'b0 || ac_control !== 2'b00)
            $display("FAIL res_hold got=v%b d%h z%b cr%b ac%b exp=v1 d%h z%b cr0 ac00",
                     res_valid, res_data, res_zero, cmd_ready, ac_control, rd, rz);
         else n_pass++;
      end
      cmd_valid = 1'b0;
      finish_res();
      @(negedge clk); #1;
      n_total++;
      if (busy !== 1'b0 || cmd_ready !== 1'b1) $display("FAIL stall_idle got=busy%b cr%b exp=busy0 cr1", busy, cmd_ready);
      else n_pass++;
   endtask

   task automatic test_reset_mid();
      logic [15:0] rd; logic rz; int e, nhs, bw, orq; bit ok;
      @(negedge clk);
      cmd_valid = 1'b1; cmd_dir = 1'b0; cmd_count = 4'd4; cmd_shift = 4'd2;
      @(posedge clk);
      @(negedge clk); cmd_valid = 1'b0; opnd_valid = 1'b1; opnd_data = 16'd11;
      @(posedge clk);
      @(negedge clk); opnd_data = 16'd22;
      @(posedge clk);
      @(negedge clk); #2;
      rst_n = 1'b0;
      #1;
      n_total++;
      if ({cmd_ready, opnd_ready, res_valid, busy, ac_control, alu_control} !== 9'b1000_00_000 ||
          bus_to_ac !== 16'd0 || inst_to_alu !== 7'd0)
         $display("FAIL reset_mid got=%b bus=%h inst=%h exp=100000000 0000 00",
                  {cmd_ready, opnd_ready, res_valid, busy, ac_control, alu_control}, bus_to_ac, inst_to_alu);
      else n_pass++;
      opnd_valid = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      ops[0] = 16'd7;
      run_cmd(1'b0, 1, 0, 0, 0, 1'b0, rd, rz, e, nhs, bw, orq, ok);
      n_total++;
      if (!ok || rd !== 16'd7 || rz !== 1'b0 || e != 2)
         $display("FAIL after_reset got=ok%0d %0d/%b e%0d exp=ok1 7/0 e2", ok, rd, rz, e);
      else n_pass++;
      finish_res();
   endtask

   task automatic test_back_to_back();
      logic [15:0] rd, exp; logic rz; int e, nhs, bw, orq; bit ok;
      for (int k = 0; k < 2; k++) begin
         ops[0] = 16'(k * 9 + 3); ops[1] = 16'd5;
         exp = ref_result(1'b1, 2, k);
         run_cmd(1'b1, 2, k, 0, 0, 1'b0, rd, rz, e, nhs, bw, orq, ok);
         n_total++;
         if (!ok || rd !== exp) $display("FAIL b2b_data got=ok%0d %h exp=ok1 %h", ok, rd, exp);
         else n_pass++;
         finish_res();
         #3;
         n_total++;
         if (cmd_ready !== 1'b1) $display("FAIL b2b_ready got=%b exp=1", cmd_ready);
         else n_pass++;
      end
   endtask

   task automatic test_random();
      logic [15:0] rd, exp; logic rz; int e, nhs, bw, orq; bit ok;
      logic d; int cnt, sh, bmax;
      for (int it = 0; it < 40; it++) begin
         d    = 1'($urandom_range(1, 0));
         cnt  = $urandom_range(15, 0);
         sh   = $urandom_range(15, 0);
         bmax = (it % 2 == 0) ? 0 : 2;
         for (int i = 0; i < 16; i++)
            ops[i] = ($urandom_range(3, 0) == 0) ? 16'hFFFF : 16'($urandom);
         if (it % 7 == 3) for (int i = 0; i < 16; i++) ops[i] = 16'd0;
         exp = ref_result(d, cnt, sh);
         run_cmd(d, cnt, sh, 0, bmax, 1'b1, rd, rz, e, nhs, bw, orq, ok);
         n_total++;
         if (!ok || rd !== exp || rz !== (exp == 16'd0))
            $display("FAIL rand_%0d got=ok%0d %h/%b exp=ok1 %h/%b (d%0d n%0d s%0d)",
                     it, ok, rd, rz, exp, (exp == 16'd0), d, cnt, sh);
         else n_pass++;
         n_total++;
         if (nhs != cnt || bw != 0) $display("FAIL rand_opnds_%0d got=%0d/%0d exp=%0d/0", it, nhs, bw, cnt);
         else n_pass++;
         if (bmax == 0) begin
            n_total++;
            if (e != ref_edges(d, cnt, sh)) $display("FAIL rand_lat_%0d got=%0d exp=%0d", it, e, ref_edges(d, cnt, sh));
            else n_pass++;
         end
         repeat ($urandom_range(3, 0)) @(negedge clk);
         finish_res();
      end
   endtask

   initial begin
      test_reset();
      test_average();
      test_empty();
      test_wrap_shl();
      test_stalls();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule : tb_ac_seq_ctrl
`default_nettype wire
